// File: rtl/io_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : io_uart_tx
// Purpose  : Memory-mapped 8N1 UART transmitter with a small byte FIFO.
//            Registers: 0x0 TXDATA, 0x4 STATUS, 0x8 BAUDDIV, 0xC CTRL.
// Revision : 1.0  initial release
// ============================================================================
module io_uart_tx #(
  parameter int          DEPTH       = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addressIO,
  input  logic [31:0] dataInIO,
  input  logic        wEnIO,
  output logic [31:0] dataOutIO,
  output logic        txd,
  output logic        irq
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [3:0]    count_q;
  logic [3:0]    count_d;
  logic          ovf_q;
  logic [15:0]   baud_q;
  logic [1:0]    ctrl_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_idx_q;
  logic [15:0]   baud_cnt_q;
  logic          txd_q;
  logic          irq_q;

  logic sel_tx, sel_st, sel_bd, sel_ct;
  logic fifo_empty, fifo_full;
  logic push, pop, bit_end;
  logic [7:0] head;
  logic unused_bits;

  assign sel_tx = wEnIO && (addressIO[3:2] == 2'd0);
  assign sel_st = wEnIO && (addressIO[3:2] == 2'd1);
  assign sel_bd = wEnIO && (addressIO[3:2] == 2'd2);
  assign sel_ct = wEnIO && (addressIO[3:2] == 2'd3);

  assign fifo_empty = (count_q == 4'd0);
  assign fifo_full  = (count_q == DEPTH_C);
  // Acceptance looks only at the pre-edge count, so a same-edge pop never
  // makes room for a push into a full FIFO.
  assign push       = sel_tx && !fifo_full;
  assign bit_end    = (baud_cnt_q == 16'd0);
  // Pops happen from IDLE, or at the very end of a stop bit for back-to-back frames.
  assign pop        = ctrl_q[0] && !fifo_empty &&
                      ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  assign head       = mem_q[rd_ptr_q];
  assign count_d    = count_q + {3'd0, push} - {3'd0, pop};

  assign unused_bits = ^{dataInIO[31:16], addressIO[1:0]};

  // Control/status registers written by the CPU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q <= DEFAULT_DIV;
      ctrl_q <= 2'd0;
      ovf_q  <= 1'b0;
    end else begin
      if (sel_bd) baud_q <= dataInIO[15:0];
      if (sel_ct) ctrl_q <= dataInIO[1:0];
      if (sel_tx && fifo_full)         ovf_q <= 1'b1;
      else if (sel_st && dataInIO[3])  ovf_q <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dataInIO[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // TX state machine: framing, per-bit period latching, registered txd and irq
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      txd_q      <= 1'b1;
      irq_q      <= 1'b0;
      shift_q    <= 8'd0;
      bit_idx_q  <= 3'd0;
      baud_cnt_q <= 16'd0;
    end else begin
      irq_q <= ctrl_q[1] & fifo_empty & (state_q == IDLE);
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q    <= head;
            baud_cnt_q <= baud_q;
            txd_q      <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            txd_q      <= shift_q[0];
            shift_q    <= {1'b0, shift_q[7:1]};
            bit_idx_q  <= 3'd0;
            baud_cnt_q <= baud_q;
            state_q    <= DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt_q <= baud_q;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              txd_q     <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift_q    <= head;
              baud_cnt_q <= baud_q;
              txd_q      <= 1'b0;
              state_q    <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Zero-latency register read mux
  always_comb begin
    dataOutIO = 32'd0;
    case (addressIO[3:2])
      2'd1:    dataOutIO = {24'd0, count_q, ovf_q, (state_q != IDLE), fifo_full, fifo_empty};
      2'd2:    dataOutIO = {16'd0, baud_q};
      2'd3:    dataOutIO = {30'd0, ctrl_q};
      default: dataOutIO = 32'd0;
    endcase
  end

  assign txd = txd_q;
  assign irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_io_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_uart_tx
// Purpose  : Self-checking bench for io_uart_tx: register vector table,
//            directed framing/reset sequences and random traffic compared
//            against a frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_io_uart_tx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addressIO = 4'h0;
  logic [31:0] dataInIO = 32'd0;
  logic        wEnIO = 1'b0;
  logic [31:0] dataOutIO;
  logic        txd;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  io_uart_tx #(.DEPTH(DEPTH), .DEFAULT_DIV(16'd433)) dut (
    .clk       (clk),
    .rst       (rst),
    .addressIO (addressIO),
    .dataInIO  (dataInIO),
    .wEnIO     (wEnIO),
    .dataOutIO (dataOutIO),
    .txd       (txd),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // ---------------- reference model (frame level) ----------------
  logic [7:0]  mq[$];
  logic [7:0]  m_cur;
  int          m_k, m_bd;
  bit          m_act, m_ovf, m_irq;
  logic [15:0] m_baud;
  logic [1:0]  m_ctrl;

  task automatic model_reset();
    mq.delete();
    m_act = 0; m_ovf = 0; m_irq = 0; m_k = 0; m_bd = 0; m_cur = 8'd0;
    m_baud = 16'd433; m_ctrl = 2'd0;
  endtask

  // Advance the model across one rising edge with the given write.
  task automatic model_step(input bit we, input logic [3:0] a, input logic [31:0] d);
    int cnt;
    cnt   = mq.size();
    m_irq = m_ctrl[1] && (cnt == 0) && !m_act;
    if (m_act) begin
      m_k++;
      if (m_k == 10 * (m_bd + 1)) m_act = 0;
    end
    if (!m_act && m_ctrl[0] && cnt > 0) begin
      m_cur = mq.pop_front();
      m_k   = 0;
      m_bd  = int'(m_baud);
      m_act = 1;
    end
    if (we) begin
      case (a[3:2])
        2'd0: if (cnt < DEPTH) mq.push_back(d[7:0]); else m_ovf = 1;
        2'd1: if (d[3]) m_ovf = 0;
        2'd2: m_baud = d[15:0];
        default: m_ctrl = d[1:0];
      endcase
    end
  endtask

  function automatic logic exp_txd();
    int b;
    if (!m_act) return 1'b1;
    b = m_k / (m_bd + 1);
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  function automatic logic [31:0] exp_status();
    logic [3:0] c;
    c = 4'(mq.size());
    return {24'd0, c, m_ovf, m_act, (mq.size() == DEPTH), (mq.size() == 0)};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // One clock: drive inputs, step model at the edge, compare 1 time unit later.
  task automatic cycle(input bit we, input logic [3:0] a, input logic [31:0] d);
    addressIO = a; dataInIO = d; wEnIO = we;
    @(posedge clk);
    model_step(we, a, d);
    #1;
    wEnIO = 1'b0;
    chk("txd", {31'd0, txd}, {31'd0, exp_txd()});
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    if (!we && a[3:2] == 2'd1) chk("status", dataOutIO, exp_status());
  endtask

  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];
  int   pat[10];

  initial begin
    int busy, first_irq, lows, r;

    vecs[0]  = '{1'b0, 4'h4, 32'h0,         4'h4, 32'h0000_0001};
    vecs[1]  = '{1'b0, 4'h4, 32'h0,         4'h8, 32'h0000_01b1};
    vecs[2]  = '{1'b0, 4'h4, 32'h0,         4'hC, 32'h0000_0000};
    vecs[3]  = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_0000};
    vecs[4]  = '{1'b1, 4'h8, 32'hABCD_0003, 4'h9, 32'h0000_0003};
    vecs[5]  = '{1'b1, 4'hC, 32'hFFFF_FFF0, 4'hC, 32'h0000_0000};
    vecs[6]  = '{1'b1, 4'h0, 32'h0000_0011, 4'h4, 32'h0000_0010};
    vecs[7]  = '{1'b1, 4'h1, 32'h0000_0022, 4'h5, 32'h0000_0020};
    vecs[8]  = '{1'b1, 4'h2, 32'h0000_0033, 4'h6, 32'h0000_0030};
    vecs[9]  = '{1'b1, 4'h3, 32'h0000_0044, 4'h7, 32'h0000_0042};
    vecs[10] = '{1'b1, 4'h0, 32'h0000_0055, 4'h4, 32'h0000_004a};
    vecs[11] = '{1'b1, 4'h4, 32'hFFFF_FFF7, 4'h4, 32'h0000_004a};
    vecs[12] = '{1'b1, 4'h4, 32'h0000_0008, 4'h4, 32'h0000_0042};
    vecs[13] = '{1'b0, 4'h4, 32'h0,         4'hE, 32'h0000_0000};
    vecs[14] = '{1'b1, 4'hC, 32'h0000_0002, 4'hF, 32'h0000_0002};
    vecs[15] = '{1'b1, 4'hC, 32'h0000_0000, 4'hC, 32'h0000_0000};
    pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_txd", {31'd0, txd}, 32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;

    // Register vector table (reset reads, aliases, FIFO fill/overflow/clear)
    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      addressIO = vecs[i].raddr;
      #1;
      chk($sformatf("vec%0d", i), dataOutIO, vecs[i].exp);
    end

    // Four queued frames back-to-back once CTRL=3
    cycle(1'b1, 4'hC, 32'd3);
    busy = 0; first_irq = -1;
    for (int k = 1; k <= 200; k++) begin
      cycle(1'b0, 4'h4, 32'd0);
      if (dataOutIO[2]) busy++;
      if (irq && first_irq < 0) first_irq = k;
    end
    chk("b2b_busy_clocks", busy, 160);
    chk("b2b_irq_rise", first_irq, 162);

    // Single 0xA5 frame at BAUDDIV=3
    cycle(1'b1, 4'hC, 32'd1);
    cycle(1'b1, 4'h0, 32'hA5);
    chk("a5_latency_pre", {31'd0, txd}, 32'd1);
    busy = 0;
    for (int k = 1; k <= 41; k++) begin
      cycle(1'b0, 4'h4, 32'd0);
      if (dataOutIO[2]) busy++;
      if (k % 4 == 0 && k <= 40) chk($sformatf("a5_bit%0d", k/4 - 1), {31'd0, txd}, pat[k/4 - 1]);
    end
    chk("a5_busy_clocks", busy, 40);
    chk("a5_status_after", dataOutIO, 32'h1);

    // tx_en cleared during the third data bit
    cycle(1'b1, 4'hC, 32'd0);
    cycle(1'b1, 4'h0, 32'h3C);
    cycle(1'b1, 4'h0, 32'h5A);
    cycle(1'b1, 4'hC, 32'd1);
    for (int k = 1; k <= 60; k++) begin
      if (k == 13) cycle(1'b1, 4'hC, 32'd0);
      else         cycle(1'b0, 4'h4, 32'd0);
    end
    chk("hold_status", dataOutIO, 32'h10);
    chk("hold_txd", {31'd0, txd}, 32'd1);
    cycle(1'b1, 4'hC, 32'd1);
    chk("resume_pre", {31'd0, txd}, 32'd1);
    cycle(1'b0, 4'h4, 32'd0);
    chk("resume_start", {31'd0, txd}, 32'd0);
    repeat (45) cycle(1'b0, 4'h4, 32'd0);

    // Asynchronous reset in the middle of a frame
    cycle(1'b1, 4'h0, 32'h96);
    repeat (10) cycle(1'b0, 4'h4, 32'd0);
    #2;
    rst = 1'b1;
    addressIO = 4'h4;
    #1;
    chk("rst_mid_txd", {31'd0, txd}, 32'd1);
    chk("rst_mid_status", dataOutIO, 32'h1);
    chk("rst_mid_irq", {31'd0, irq}, 32'd0);
    addressIO = 4'h8;
    #1;
    chk("rst_mid_baud", dataOutIO, 32'h1b1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    lows = 0;
    for (int k = 0; k < 50; k++) begin
      cycle(1'b0, 4'h4, 32'd0);
      if (!txd) lows++;
    end
    chk("post_rst_quiet", lows, 0);

    // Random traffic against the model
    cycle(1'b1, 4'h8, 32'd0);
    cycle(1'b1, 4'hC, 32'd1);
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25)
        cycle(1'b1, 4'h0, $urandom & 32'hFF);
      else if (r < 30)
        cycle(1'b1, 4'hC, $urandom_range(0, 3));
      else if (r < 33)
        cycle(1'b1, 4'h4, 32'h8);
      else if (r < 36 && !m_act && (mq.size() == 0 || !m_ctrl[0]))
        cycle(1'b1, 4'h8, $urandom_range(0, 2));
      else
        cycle(1'b0, 4'h4, 32'd0);
    end
    cycle(1'b1, 4'hC, 32'd1);
    for (int j = 0; j < 3000 && (m_act || mq.size() != 0); j++)
      cycle(1'b0, 4'h4, 32'd0);
    cycle(1'b1, 4'h4, 32'h8);
    cycle(1'b0, 4'h4, 32'd0);
    chk("drain_status", dataOutIO, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
